// File: rtl/pipe_payload_buffer.sv
// Per-channel payload pipeline with per-stage stall/flush and occupancy summaries.
// Build option: define PBUF_CLEAR_DATA_EN to zero payload words on bubbles and flushes.
module pipe_payload_buffer #(
  parameter int NCH  = 2,
  parameter int NSTG = 5,
  parameter int W    = 32,
  parameter int FIRST [NCH] = '{default: 0},
  parameter int LAST  [NCH] = '{default: NSTG-1}
) (
  input  logic                                  clk,
  input  logic                                  grst,
  input  logic [NSTG-1:0]                       stall,
  input  logic [NSTG-1:0]                       flush,
  input  logic [NCH-1:0]                        in_valid,
  input  logic [NCH-1:0][W-1:0]                 in_data,
  output logic [NCH-1:0][NSTG-1:0][W-1:0]       data,
  output logic [NCH-1:0][NSTG-1:0]              valid,
  output logic [NSTG-1:0]                       stage_busy,
  output logic [NCH-1:0][$clog2(NSTG+1)-1:0]    chan_count
);

  localparam int CW = $clog2(NSTG+1);

`ifdef PBUF_CLEAR_DATA_EN
  localparam bit CLEAR_DATA = 1'b1;
`else
  localparam bit CLEAR_DATA = 1'b0;
`endif

  // Flat view of every slot; unimplemented slots are tied to zero.
  logic         valid_q [NCH][NSTG];
  logic [W-1:0] data_q  [NCH][NSTG];

  for (genvar gc = 0; gc < NCH; gc++) begin : g_ch
    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
      if (gi >= FIRST[gc] && gi <= LAST[gc]) begin : g_slot
        logic         valid_reg;
        logic [W-1:0] data_reg;
        logic         valid_next;
        logic [W-1:0] data_next;
        logic         src_ok;
        logic         src_valid;
        logic [W-1:0] src_data;

        // The upstream stage only hands its content forward when it is not held.
        if (gi == 0) begin : g_src_ok_top
          assign src_ok = 1'b1;
        end else begin : g_src_ok_mid
          assign src_ok = ~stall[gi-1];
        end

        if (gi == FIRST[gc]) begin : g_src_ins
          assign src_valid = in_valid[gc];
          assign src_data  = in_data[gc];
        end else begin : g_src_prev
          assign src_valid = valid_q[gc][gi-1];
          assign src_data  = data_q[gc][gi-1];
        end

        always_comb begin
          valid_next = valid_reg;
          data_next  = data_reg;
          if (flush[gi]) begin
            valid_next = 1'b0;
            if (CLEAR_DATA) data_next = '0;
          end else if (!stall[gi]) begin
            if (src_ok) begin
              valid_next = src_valid;
              data_next  = src_data;
            end else begin
              valid_next = 1'b0;
              if (CLEAR_DATA) data_next = '0;
            end
          end
        end

        always_ff @(posedge clk) begin
          if (grst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
          end else begin
            valid_reg <= valid_next;
            data_reg  <= data_next;
          end
        end

        assign valid_q[gc][gi] = valid_reg;
        assign data_q[gc][gi]  = data_reg;
      end else begin : g_empty
        assign valid_q[gc][gi] = 1'b0;
        assign data_q[gc][gi]  = '0;
      end

      assign valid[gc][gi] = valid_q[gc][gi];
      assign data[gc][gi]  = data_q[gc][gi];
    end
  end

  always_comb begin
    stage_busy = '0;
    chan_count = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int s = 0; s < NSTG; s++) begin
        stage_busy[s] = stage_busy[s] | valid_q[c][s];
        chan_count[c] = chan_count[c] + CW'(valid_q[c][s]);
      end
    end
  end

endmodule

// File: tb/tb_pipe_payload_buffer.sv
// Randomized and directed bench for pipe_payload_buffer against a slot-array reference model.
module tb_pipe_payload_buffer;
  localparam int NCH  = 2;
  localparam int NSTG = 5;
  localparam int W    = 32;
  localparam int CW   = $clog2(NSTG+1);
  localparam int FIRST_C [NCH] = '{0, 1};
  localparam int LAST_C  [NCH] = '{4, 3};

  logic clk = 1'b0;
  logic grst;
  logic [NSTG-1:0] stall, flush;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0][W-1:0] in_data;
  logic [NCH-1:0][NSTG-1:0][W-1:0] data;
  logic [NCH-1:0][NSTG-1:0] valid;
  logic [NSTG-1:0] stage_busy;
  logic [NCH-1:0][CW-1:0] chan_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference: what each (channel, stage) slot holds right now.
  logic         mv [NCH][NSTG];
  logic [W-1:0] md [NCH][NSTG];

  always #5 clk = ~clk;

  pipe_payload_buffer #(
    .NCH(NCH), .NSTG(NSTG), .W(W), .FIRST(FIRST_C), .LAST(LAST_C)
  ) dut (
    .clk(clk), .grst(grst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .data(data), .valid(valid),
    .stage_busy(stage_busy), .chan_count(chan_count)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic         nv [NCH][NSTG];
    logic [W-1:0] nd [NCH][NSTG];
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < NSTG; i++) begin
        nv[c][i] = mv[c][i];
        nd[c][i] = md[c][i];
        if (i < FIRST_C[c] || i > LAST_C[c]) continue;
        if (grst) begin
          nv[c][i] = 1'b0;
          nd[c][i] = '0;
        end else if (flush[i]) begin
          nv[c][i] = 1'b0;
`ifdef PBUF_CLEAR_DATA_EN
          nd[c][i] = '0;
`endif
        end else if (stall[i]) begin
          // held
        end else if (i > 0 && stall[i-1]) begin
          nv[c][i] = 1'b0;
`ifdef PBUF_CLEAR_DATA_EN
          nd[c][i] = '0;
`endif
        end else if (i == FIRST_C[c]) begin
          nv[c][i] = in_valid[c];
          nd[c][i] = in_data[c];
        end else begin
          nv[c][i] = mv[c][i-1];
          nd[c][i] = md[c][i-1];
        end
      end
    end
    mv = nv;
    md = nd;
  endtask

  task automatic compare_all();
    logic [NSTG-1:0] exp_busy;
    int exp_cnt;
    exp_busy = '0;
    for (int c = 0; c < NCH; c++) begin
      exp_cnt = 0;
      for (int s = 0; s < NSTG; s++) begin
        check_val($sformatf("valid[%0d][%0d]", c, s), 64'(valid[c][s]), 64'(mv[c][s]));
        check_val($sformatf("data[%0d][%0d]", c, s), 64'(data[c][s]), 64'(md[c][s]));
        exp_cnt += int'(mv[c][s]);
        if (mv[c][s]) exp_busy[s] = 1'b1;
      end
      check_val($sformatf("chan_count[%0d]", c), 64'(chan_count[c]), 64'(exp_cnt));
    end
    check_val("stage_busy", 64'(stage_busy), 64'(exp_busy));
  endtask

  task automatic drive(input logic g, input logic [NSTG-1:0] st, input logic [NSTG-1:0] fl,
                       input logic [NCH-1:0] iv, input logic [W-1:0] d0, input logic [W-1:0] d1);
    grst = g; stall = st; flush = fl; in_valid = iv;
    in_data[0] = d0; in_data[1] = d1;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d grst=%b stall=%b flush=%b in_valid=%b busy=%b cnt0=%0d cnt1=%0d",
             cyc, grst, stall, flush, in_valid, stage_busy, chan_count[0], chan_count[1]);
    compare_all();
  endtask

  logic [W-1:0] exp_flushed;

  initial begin
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < NSTG; s++) begin
        mv[c][s] = 1'b0;
        md[c][s] = '0;
      end
    drive(1'b1, '0, '0, '0, '0, '0);
    step();
    step();
    check_val("rst_busy", 64'(stage_busy), 64'd0);
    check_val("rst_cnt0", 64'(chan_count[0]), 64'd0);
    check_val("rst_cnt1", 64'(chan_count[1]), 64'd0);

    // Single payload walks ch0 stages 0..4.
    drive(1'b0, '0, '0, 2'b01, 32'hA5A5_0001, '0);
    step();
    check_val("walk_s0_valid", 64'(valid[0][0]), 64'd1);
    drive(1'b0, '0, '0, 2'b00, '0, '0);
    repeat (4) step();
    check_val("walk_s4_valid", 64'(valid[0][4]), 64'd1);
    check_val("walk_s4_data", 64'(data[0][4]), 64'hA5A5_0001);
    step();
    check_val("walk_drop_valid", 64'(valid[0][4]), 64'd0);

    // ch1 payload held in stage 2 while stage 3 sees bubbles.
    drive(1'b0, '0, '0, 2'b10, '0, 32'h11);
    step();
    drive(1'b0, '0, '0, 2'b00, '0, '0);
    step();
    check_val("hold_pre_s2", 64'(data[1][2]), 64'h11);
    drive(1'b0, 5'b00100, '0, 2'b00, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("hold_s2_valid", 64'(valid[1][2]), 64'd1);
      check_val("hold_s2_data", 64'(data[1][2]), 64'h11);
      check_val("hold_s3_bubble", 64'(valid[1][3]), 64'd0);
    end
    drive(1'b0, '0, '0, 2'b00, '0, '0);
    step();
    check_val("release_s3_valid", 64'(valid[1][3]), 64'd1);
    check_val("release_s3_data", 64'(data[1][3]), 64'h11);

    // Flush beats stall on stage 3.
    drive(1'b0, '0, '0, 2'b01, 32'hBEEF, '0);
    step();
    drive(1'b0, '0, '0, 2'b00, '0, '0);
    repeat (3) step();
    check_val("flush_pre_valid", 64'(valid[0][3]), 64'd1);
    drive(1'b0, 5'b01000, 5'b01000, 2'b00, '0, '0);
    step();
    check_val("flush_v0", 64'(valid[0][3]), 64'd0);
    check_val("flush_v1", 64'(valid[1][3]), 64'd0);
`ifdef PBUF_CLEAR_DATA_EN
    exp_flushed = '0;
`else
    exp_flushed = 32'hBEEF;
`endif
    check_val("flush_data", 64'(data[0][3]), 64'(exp_flushed));

    // Fill all ch0 stages.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, '0, 2'b01, 32'h100 + W'(k), '0);
      step();
    end
    check_val("full_cnt0", 64'(chan_count[0]), 64'd5);
    check_val("full_busy", 64'(stage_busy), 64'h1F);
    check_val("oor_v10", 64'(valid[1][0]), 64'd0);
    check_val("oor_v14", 64'(valid[1][4]), 64'd0);
    check_val("oor_d10", 64'(data[1][0]), 64'd0);
    check_val("oor_d14", 64'(data[1][4]), 64'd0);

    // Reset mid-stream overrides stall and inserts.
    drive(1'b1, 5'b11111, '0, 2'b11, 32'hDEAD, 32'hCAFE);
    step();
    check_val("grst_valid", 64'(valid), 64'd0);
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < NSTG; s++)
        check_val($sformatf("grst_data[%0d][%0d]", c, s), 64'(data[c][s]), 64'd0);
    check_val("grst_cnt0", 64'(chan_count[0]), 64'd0);
    check_val("grst_cnt1", 64'(chan_count[1]), 64'd0);
    drive(1'b0, '0, '0, 2'b11, 32'h77, 32'h88);
    step();
    check_val("post_rst_v0", 64'(valid[0][0]), 64'd1);
    check_val("post_rst_d0", 64'(data[0][0]), 64'h77);
    check_val("post_rst_v1", 64'(valid[1][1]), 64'd1);
    check_val("post_rst_d1", 64'(data[1][1]), 64'h88);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'b0, NSTG'($urandom & $urandom), NSTG'($urandom & $urandom & $urandom & $urandom),
            NCH'($urandom), $urandom, $urandom);
      grst = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
